spi_ram_ctrl: RTL

- Sequences a single-port RAM on behalf of the SPI slave and shares it with a local host port.
- Decodes 10-bit SPI command words (rx_data[9:8] opcode, rx_data[7:0] payload) into address-register updates and RAM accesses.
- Returns read data to the SPI slave on tx_data/tx_valid.
- Arbitrates RAM access between the SPI command stream and host requests.

---
 rtl/spi_ram_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_ram_ctrl.sv
// SPI command sequencer and host arbiter for a shared single-port RAM.
// Optional round-robin SPI/host arbitration is enabled by defining SPI_RAM_RR_EN.
//
//   state        | meaning
//   IDLE         | RAM free; at most one SPI or host grant this cycle
//   SPI_RD_WAIT  | SPI read issued last cycle; capture mem_rdata into tx_data
//   HOST_RD_WAIT | host read issued last cycle; capture mem_rdata into host_rdata
module spi_ram_ctrl #(
   parameter int ADDR_SIZE = 8,
   parameter int TX_HOLD   = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [7:0]           host_wdata,
   output logic                 host_gnt,
   output logic [7:0]           host_rdata,
   output logic                 host_rvalid,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic [7:0]           mem_rdata,
   output logic                 spi_ovf
);

   typedef enum logic [1:0] {IDLE, SPI_RD_WAIT, HOST_RD_WAIT} state_t;

   state_t               state;
   logic                 rx_valid_q;
   logic                 accept;
   logic [1:0]           op;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic                 spi_pend;
   logic                 pend_we;
   logic [ADDR_SIZE-1:0] pend_addr;
   logic [7:0]           pend_data;
   logic [7:0]           tx_cnt;
   logic                 grant_spi;
   logic                 grant_host;
`ifdef SPI_RAM_RR_EN
   logic                 last_host;
`endif

   assign accept = rx_valid & ~rx_valid_q;
   assign op     = rx_data[9:8];

   // RAM strobes are decoded from registered state so an SPI op accepted in E issues in E+1
   always_comb begin
      grant_spi  = 1'b0;
      grant_host = 1'b0;
      if (state == IDLE) begin
`ifdef SPI_RAM_RR_EN
         if (spi_pend && host_req) begin
            grant_spi  = last_host;
            grant_host = ~last_host;
         end else begin
            grant_spi  = spi_pend;
            grant_host = host_req;
         end
`else
         grant_spi  = spi_pend;
         grant_host = host_req & ~spi_pend;
`endif
      end
      mem_en    = grant_spi | grant_host;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_spi) begin
         mem_we    = pend_we;
         mem_addr  = pend_addr;
         mem_wdata = pend_data;
      end else if (grant_host) begin
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
      host_gnt = grant_host;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         rx_valid_q  <= 1'b0;
         wr_addr     <= '0;
         rd_addr     <= '0;
         spi_pend    <= 1'b0;
         pend_we     <= 1'b0;
         pend_addr   <= '0;
         pend_data   <= '0;
         spi_ovf     <= 1'b0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         tx_cnt      <= '0;
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
`ifdef SPI_RAM_RR_EN
         last_host   <= 1'b1;
`endif
      end else begin
         rx_valid_q  <= rx_valid;
         host_rvalid <= 1'b0;

         if (grant_spi)
            spi_pend <= 1'b0;

         if (accept) begin
            case (op)
               2'b00: wr_addr <= rx_data[ADDR_SIZE-1:0];
               2'b10: rd_addr <= rx_data[ADDR_SIZE-1:0];
               default: begin
                  // an op being issued this very cycle is not lost, so it is not an overflow
                  if (spi_pend && !grant_spi)
                     spi_ovf <= 1'b1;
                  spi_pend  <= 1'b1;
                  pend_we   <= ~op[1];
                  pend_addr <= op[1] ? rd_addr : wr_addr;
                  pend_data <= op[1] ? 8'h00 : rx_data[7:0];
               end
            endcase
         end

`ifdef SPI_RAM_RR_EN
         if (grant_spi || grant_host)
            last_host <= grant_host;
`endif

         case (state)
            IDLE: begin
               if (grant_spi && !pend_we)
                  state <= SPI_RD_WAIT;
               else if (grant_host && !host_we)
                  state <= HOST_RD_WAIT;
            end
            SPI_RD_WAIT: begin
               tx_data <= mem_rdata;
               state   <= IDLE;
            end
            HOST_RD_WAIT: begin
               host_rdata  <= mem_rdata;
               host_rvalid <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // tx hold down-counter; a fresh capture restarts the window
         if (state == SPI_RD_WAIT) begin
            tx_valid <= 1'b1;
            tx_cnt   <= 8'(TX_HOLD);
         end else if (tx_valid) begin
            tx_cnt <= tx_cnt - 8'd1;
            if (tx_cnt == 8'd1)
               tx_valid <= 1'b0;
         end
      end
   end

endmodule
